// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: owns the program counter and the IF/ID pipeline
// register. Holds, bubbles or redirects fetch in response to branch
// stall/flush, load-use hazards and the syscall halt handshake.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_instr_i,
    input  logic        branch_stall_i,
    input  logic        branch_flush_i,
    input  logic        load_hazard_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        syscall_i,
    input  logic        host_resume_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic [15:0] stall_count_o,
    output logic [15:0] flush_count_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BR_WAIT  = 2'd1,
        ST_SYS_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_plus4_s;
    logic        stall_inc_s;
    logic        flush_inc_s;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 16'd1;
        end
    endfunction

    // Next-state, next-PC and IF/ID selection; everything holds unless a rule moves it.
    always_comb begin
        pc_plus4_s    = pc_q + 32'd4;
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        stall_inc_s   = 1'b0;
        flush_inc_s   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_hazard_i) begin
                    stall_inc_s = 1'b1;
                end else if (syscall_i) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    state_d       = ST_SYS_HALT;
                end else if (branch_stall_i) begin
                    stall_inc_s = 1'b1;
                    state_d     = ST_BR_WAIT;
                end else begin
                    if_id_pc_d    = pc_plus4_s;
                    if_id_instr_d = imem_instr_i;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_plus4_s;
                end
            end
            ST_BR_WAIT: begin
                if (load_hazard_i) begin
                    // A hazard masks a coincident flush; the branch waits one more cycle.
                    stall_inc_s = 1'b1;
                end else if (branch_flush_i) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    pc_d          = branch_taken_i ? branch_target_i : pc_plus4_s;
                    flush_inc_s   = 1'b1;
                    state_d       = ST_RUN;
                end else begin
                    stall_inc_s = 1'b1;
                end
            end
            ST_SYS_HALT: begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
                if (host_resume_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SYS_HALT;
                end
            end
            default: begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
                state_d       = ST_RUN;
            end
        endcase
        halted_d    = (state_d == ST_SYS_HALT);
        stall_cnt_d = stall_inc_s ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_inc_s ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            stall_cnt_q   <= 16'h0000;
            flush_cnt_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            halted_q      <= halted_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign pc_o          = pc_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;
    assign halted_o      = halted_q;
    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios followed by random
// control traffic, every cycle checked against a cycle-level reference model.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_instr_i;
    logic        branch_stall_i = 1'b0;
    logic        branch_flush_i = 1'b0;
    logic        load_hazard_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0000_0000;
    logic        syscall_i = 1'b0;
    logic        host_resume_i = 1'b0;
    logic [31:0] pc_o, if_id_pc_o, if_id_instr_o;
    logic        if_id_valid_o, halted_o;
    logic [15:0] stall_count_o, flush_count_o;

    // second instance with a reset PC at the top of the address space
    logic [31:0] w_imem, w_pc, w_if_pc, w_if_instr;
    logic        w_valid, w_halted;
    logic [15:0] w_stall, w_flush;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc, m_ifpc, m_instr, w_mpc, w_mifpc;
    logic        m_valid, m_halt, m_bw;
    logic [15:0] m_stall, m_flush;

    always #5 clk = ~clk;

    // instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_instr_i = imem(pc_o);
    assign w_imem       = imem(w_pc);

    fetch_redirect_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_instr_i(imem_instr_i),
        .branch_stall_i(branch_stall_i), .branch_flush_i(branch_flush_i),
        .load_hazard_i(load_hazard_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .syscall_i(syscall_i),
        .host_resume_i(host_resume_i), .pc_o(pc_o), .if_id_pc_o(if_id_pc_o),
        .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
        .halted_o(halted_o), .stall_count_o(stall_count_o),
        .flush_count_o(flush_count_o)
    );

    fetch_redirect_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_instr_i(w_imem),
        .branch_stall_i(1'b0), .branch_flush_i(1'b0), .load_hazard_i(1'b0),
        .branch_taken_i(1'b0), .branch_target_i(32'h0000_0000),
        .syscall_i(1'b0), .host_resume_i(1'b0), .pc_o(w_pc),
        .if_id_pc_o(w_if_pc), .if_id_instr_o(w_if_instr),
        .if_id_valid_o(w_valid), .halted_o(w_halted),
        .stall_count_o(w_stall), .flush_count_o(w_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // advance the reference model by one clock using the inputs just sampled
    task automatic model_tick();
        if (!rst_n) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_halt = 1'b0; m_bw = 1'b0; m_stall = 16'h0; m_flush = 16'h0;
            w_mpc = 32'hFFFF_FFFC; w_mifpc = 32'h0;
        end else begin
            w_mifpc = w_mpc + 32'd4;
            w_mpc   = w_mpc + 32'd4;
            if (m_halt) begin
                if (host_resume_i) m_halt = 1'b0;
            end else if (m_bw) begin
                if (load_hazard_i) m_stall = sat(m_stall);
                else if (branch_flush_i) begin
                    m_instr = 32'h0; m_valid = 1'b0; m_bw = 1'b0;
                    m_pc = branch_taken_i ? branch_target_i : m_pc + 32'd4;
                    m_flush = sat(m_flush);
                end else m_stall = sat(m_stall);
            end else begin
                if (load_hazard_i) m_stall = sat(m_stall);
                else if (syscall_i) begin
                    m_instr = 32'h0; m_valid = 1'b0; m_halt = 1'b1;
                end else if (branch_stall_i) begin
                    m_stall = sat(m_stall); m_bw = 1'b1;
                end else begin
                    m_ifpc = m_pc + 32'd4; m_instr = imem(m_pc);
                    m_valid = 1'b1; m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("pc", pc_o, m_pc);
        chk("if_id_pc", if_id_pc_o, m_ifpc);
        chk("if_id_instr", if_id_instr_o, m_instr);
        chk("if_id_valid", {31'd0, if_id_valid_o}, {31'd0, m_valid});
        chk("halted", {31'd0, halted_o}, {31'd0, m_halt});
        chk("stall_count", {16'd0, stall_count_o}, {16'd0, m_stall});
        chk("flush_count", {16'd0, flush_count_o}, {16'd0, m_flush});
        chk("wrap_pc", w_pc, w_mpc);
        chk("wrap_if_id_pc", w_if_pc, w_mifpc);
    endtask

    // one clock: drive inputs, clock, update model, sample #1 after the edge
    task automatic step(input logic rst, input logic lh, input logic bs,
                        input logic bf, input logic bt, input logic [31:0] tgt,
                        input logic sc, input logic hr);
        rst_n = rst; load_hazard_i = lh; branch_stall_i = bs;
        branch_flush_i = bf; branch_taken_i = bt; branch_target_i = tgt;
        syscall_i = sc; host_resume_i = hr;
        @(posedge clk);
        model_tick();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset for two cycles, then straight-line fetch to pc 0x10
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("reset_pc", pc_o, 32'h0000_0000);
        chk("reset_valid", {31'd0, if_id_valid_o}, 32'd0);
        idle(3);
        chk("fetch3_if_id_pc", if_id_pc_o, 32'h0000_000C);
        chk("wrap_to_zero", w_pc, 32'h0000_0008);
        idle(1);
        chk("at_0x10", pc_o, 32'h0000_0010);

        // taken branch to 0x40
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("br_hold", pc_o, 32'h0000_0010);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
        chk("br_target", pc_o, 32'h0000_0040);
        chk("br_flush_cnt", {16'd0, flush_count_o}, 32'd1);
        chk("br_stall_cnt", {16'd0, stall_count_o}, 32'd1);

        // load hazard masks the flush, then a not-taken flush
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b0);
        chk("lh_not_taken", pc_o, 32'h0000_0044);
        chk("lh_stall_cnt", {16'd0, stall_count_o}, 32'd3);

        // fetch to 0x20 after a fresh reset, then syscall with delayed resume
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(8);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("sys_halted", {31'd0, halted_o}, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("sys_pc_held", pc_o, 32'h0000_0020);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("sys_resumed", {31'd0, halted_o}, 32'd0);
        idle(1);
        chk("sys_fetch_restart", if_id_pc_o, 32'h0000_0024);

        // reset in the middle of a halt
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_mid_halt", {31'd0, halted_o}, 32'd0);
        idle(2);

        // branch to the last word so the fetch wraps to zero
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        idle(1);
        chk("pc_wrap", pc_o, 32'h0000_0000);

        // stall-counter saturation
        for (int i = 0; i < 70000; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_saturated", {16'd0, stall_count_o}, 32'h0000_FFFF);

        // random control traffic
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom(),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 30));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
